idli_sqi_arb_m: RTL and testbench
=================================

// Module: idli_sqi_arb_m
// PURPOSE
//  Sequences the single external quad-SPI (SQI) serial RAM and shares it between the
//  core's instruction-fetch port (read-only) and data load/store port (read/write).
//  Builds the nibble-serial frame: command, address, dummy, data. Generates SCK, CS and
//  the pad drive-enable, and returns one-cycle completion pulses to the requesters.
//  Sits between the core pipeline and the top-level uio pads.
// PARAMETERS
//  ADDR_W     16  address bits sent per frame; must be a multiple of 4 (ADDR_W/4 nibbles)
//  DATA_W     16  data word bits per frame; must be a multiple of 4 (DATA_W/4 nibbles)
//  DUMMY_NIB  2   dummy nibbles between address and read data (reads only)
// PORTS
//  i_arb_gck          in   1       clock; all logic is clocked on the rising edge
//  i_arb_rst          in   1       synchronous reset, active-high
//  i_arb_f_req        in   1       fetch request; held high until o_arb_f_done
//  i_arb_f_addr       in   ADDR_W  fetch address
//  o_arb_f_done       out  1       one-cycle pulse: fetch complete, o_arb_f_rdata valid
//  o_arb_f_rdata      out  DATA_W  fetch read data
//  i_arb_d_req        in   1       data request; held high until o_arb_d_done
//  i_arb_d_wr         in   1       1 = write, 0 = read
//  i_arb_d_addr       in   ADDR_W  data address
//  i_arb_d_wdata      in   DATA_W  write data
//  o_arb_d_done       out  1       one-cycle pulse: data access complete; rdata valid on reads
//  o_arb_d_rdata      out  DATA_W  data read data
//  o_arb_sqi_sck      out  1       serial clock at gck/2
//  o_arb_sqi_cs       out  1       chip select, active-low
//  o_arb_sqi_mode     out  1       1 = pads drive o_arb_sqi_data, 0 = pads input
//  o_arb_sqi_data     out  4       outbound nibble
//  i_arb_sqi_data     in   4       inbound nibble
// BEHAVIOUR
//  Reset: FSM=IDLE; sck=0, cs=1, mode=0, sqi_data=0, both done=0, rdata=0, RR pointer=fetch.
//  FSM: IDLE -> CMD(2 nib) -> ADDR(ADDR_W/4) -> [DUMMY(DUMMY_NIB), read only] -> DATA(DATA_W/4)
//    -> DONE -> IDLE.
//  IDLE: with any req high, grant one requester. Latch op, addr, wdata; move to CMD.
//    Later changes on requester inputs are ignored until done.
//  Each nibble takes 2 cycles: phase0 sck=0 with new nibble driven, phase1 sck=1.
//    Inbound nibble sampled at the clock edge ending phase1. All nibbles are MSB-first.
//  cs=0 through CMD..DATA. Command: 8'h03 read, 8'h02 write.
//  mode=1 in CMD, ADDR and write DATA; mode=0 in IDLE, DUMMY, read DATA and DONE.
//  DONE: cs=1, sck=0, granted port's done=1 for exactly this cycle, rdata updated.
//    IDLE always follows DONE, so cs stays high for at least 2 cycles.
//  Latency, defaults (req sampled in IDLE at cycle 0): read done at cycle 25, write at 21.
//  Read rdata holds its value until the next completion on that port.
//  Never more than one done pulse per cycle. Never more than one frame in flight.
//  Dropping a req after grant is illegal; the frame completes and done still pulses.
//  Reset mid-frame: FSM returns to IDLE next cycle, cs=1, no done pulse, frame abandoned.
// CONFIGURATION
//  IDLI_SQI_ARB_RR_EN defined: round-robin. When both ports request in IDLE, grant the
//    port not granted last; the pointer updates on each grant.
//  Not defined: fixed priority, data over fetch. Fetch may starve and this is accepted.
//  Single-requester behaviour is identical in both builds.
// TESTING
//  Fetch read addr 16'h1234, memory model returns 16'hBEEF -> sqi_data 0,3,1,2,3,4;
//    f_done at cycle 25, f_rdata=16'hBEEF.
//  Data write addr 16'h00A0 wdata 16'hCAFE -> nibbles 0,2,0,0,A,0,C,A,F,E with mode=1;
//    d_done at cycle 21.
//  Both req in the same IDLE cycle, twice back-to-back -> RR build: data then fetch;
//    fixed build: data twice.
//  Reset asserted during ADDR -> next cycle cs=1, mode=0, IDLE; no done; held req restarts
//    at CMD.
//  Change i_arb_d_addr/wdata after grant -> frame uses the latched values.
//  Check cs high >=2 cycles between frames and sck toggles only while cs=0.

Source files
------------

// File: rtl/idli_sqi_arb_m_if.sv
// Request/response and SQI pad bundle for the SQI arbiter.
// slave = arbiter side, master = core/pad side.
interface idli_sqi_arb_m_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_done;
    logic [DATA_W-1:0] f_rdata;

    logic              d_req;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;

    logic              sqi_sck;
    logic              sqi_cs;
    logic              sqi_mode;
    logic [3:0]        sqi_dout;
    logic [3:0]        sqi_din;

    modport slave (
        input  f_req, f_addr, d_req, d_wr, d_addr, d_wdata, sqi_din,
        output f_done, f_rdata, d_done, d_rdata, sqi_sck, sqi_cs, sqi_mode, sqi_dout
    );

    modport master (
        output f_req, f_addr, d_req, d_wr, d_addr, d_wdata, sqi_din,
        input  f_done, f_rdata, d_done, d_rdata, sqi_sck, sqi_cs, sqi_mode, sqi_dout
    );
endinterface

// File: rtl/idli_sqi_arb_m.sv
// Shares one quad-SPI serial RAM between the fetch and data ports, one frame at a time.
// Define IDLI_SQI_ARB_RR_EN for round-robin arbitration; otherwise data has fixed priority.
module idli_sqi_arb_m #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int DUMMY_NIB = 2
) (
    input  logic              i_arb_gck,
    input  logic              i_arb_rst,
    idli_sqi_arb_m_if.slave   bus
);
    localparam int TX_W = 8 + ADDR_W + DATA_W;
    localparam logic [7:0] CMD_LAST   = 8'(2 - 1);
    localparam logic [7:0] ADDR_LAST  = 8'(ADDR_W / 4 - 1);
    localparam logic [7:0] DUMMY_LAST = 8'((DUMMY_NIB > 0) ? DUMMY_NIB - 1 : 0);
    localparam logic [7:0] DATA_LAST  = 8'(DATA_W / 4 - 1);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DONE} state_t;

    state_t            state_reg, state_next;
    logic              phase_reg;
    logic [7:0]        nib_cnt_reg;
    logic              gnt_d_reg;
    logic              wr_reg;
    logic [TX_W-1:0]   tx_reg;
    logic [DATA_W-1:0] rx_reg;
    logic [DATA_W-1:0] f_rdata_reg;
    logic [DATA_W-1:0] d_rdata_reg;

    logic              start;
    logic              pick_d;
    logic              nib_last;
    logic              seg_end;
    logic              framing;
    logic              shifting;
    logic              rx_active;
    logic [DATA_W-1:0] rx_next;

`ifdef IDLI_SQI_ARB_RR_EN
    // Remembers whether the most recent grant went to the data port.
    logic last_d_reg;

    always_ff @(posedge i_arb_gck) begin
        if (i_arb_rst) begin
            last_d_reg <= 1'b0;
        end else if (start) begin
            last_d_reg <= pick_d;
        end
    end

    assign pick_d = bus.d_req && (!bus.f_req || !last_d_reg);
`else
    assign pick_d = bus.d_req;
`endif

    always_comb begin
        nib_last = 1'b0;
        case (state_reg)
            S_CMD:   nib_last = (nib_cnt_reg == CMD_LAST);
            S_ADDR:  nib_last = (nib_cnt_reg == ADDR_LAST);
            S_DUMMY: nib_last = (nib_cnt_reg == DUMMY_LAST);
            S_DATA:  nib_last = (nib_cnt_reg == DATA_LAST);
            default: nib_last = 1'b0;
        endcase
    end

    assign seg_end   = phase_reg && nib_last;
    assign framing   = (state_reg == S_CMD) || (state_reg == S_ADDR) ||
                       (state_reg == S_DUMMY) || (state_reg == S_DATA);
    assign shifting  = (state_reg == S_CMD) || (state_reg == S_ADDR) ||
                       ((state_reg == S_DATA) && wr_reg);
    assign rx_active = (state_reg == S_DATA) && !wr_reg;
    assign rx_next   = {rx_reg[DATA_W-5:0], bus.sqi_din};

    always_comb begin
        state_next = state_reg;
        start      = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (bus.f_req || bus.d_req) begin
                    start      = 1'b1;
                    state_next = S_CMD;
                end
            end
            S_CMD:   if (seg_end) state_next = S_ADDR;
            S_ADDR: begin
                if (seg_end) begin
                    state_next = (wr_reg || DUMMY_NIB == 0) ? S_DATA : S_DUMMY;
                end
            end
            S_DUMMY: if (seg_end) state_next = S_DATA;
            S_DATA:  if (seg_end) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Nibble timing: phase 0 drives the nibble with sck low, phase 1 raises sck.
    always_ff @(posedge i_arb_gck) begin
        if (i_arb_rst) begin
            state_reg   <= S_IDLE;
            phase_reg   <= 1'b0;
            nib_cnt_reg <= 8'd0;
        end else begin
            state_reg <= state_next;
            if (state_next != state_reg) begin
                phase_reg   <= 1'b0;
                nib_cnt_reg <= 8'd0;
            end else if (framing) begin
                phase_reg <= ~phase_reg;
                if (phase_reg) begin
                    nib_cnt_reg <= nib_cnt_reg + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge i_arb_gck) begin
        if (i_arb_rst) begin
            gnt_d_reg   <= 1'b0;
            wr_reg      <= 1'b0;
            tx_reg      <= '0;
            rx_reg      <= '0;
            f_rdata_reg <= '0;
            d_rdata_reg <= '0;
        end else begin
            if (start) begin
                gnt_d_reg <= pick_d;
                wr_reg    <= pick_d && bus.d_wr;
                tx_reg    <= {(pick_d && bus.d_wr) ? 8'h02 : 8'h03,
                              pick_d ? bus.d_addr : bus.f_addr,
                              bus.d_wdata};
            end else if (phase_reg && shifting) begin
                tx_reg <= tx_reg << 4;
            end
            if (phase_reg && rx_active) begin
                rx_reg <= rx_next;
                if (nib_last) begin
                    if (gnt_d_reg) d_rdata_reg <= rx_next;
                    else           f_rdata_reg <= rx_next;
                end
            end
        end
    end

    assign bus.sqi_cs   = !framing;
    assign bus.sqi_sck  = framing && phase_reg;
    assign bus.sqi_mode = shifting;
    assign bus.sqi_dout = shifting ? tx_reg[TX_W-1 -: 4] : 4'h0;
    assign bus.f_done   = (state_reg == S_DONE) && !gnt_d_reg;
    assign bus.d_done   = (state_reg == S_DONE) && gnt_d_reg;
    assign bus.f_rdata  = f_rdata_reg;
    assign bus.d_rdata  = d_rdata_reg;
endmodule

// File: tb/tb_idli_sqi_arb_m.sv
// Directed bench for idli_sqi_arb_m with a behavioural SQI RAM model.
module tb_idli_sqi_arb_m;
`ifdef IDLI_SQI_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    idli_sqi_arb_m_if #(.ADDR_W(16), .DATA_W(16)) bus();

    idli_sqi_arb_m #(.ADDR_W(16), .DATA_W(16), .DUMMY_NIB(2)) dut (
        .i_arb_gck (clk),
        .i_arb_rst (rst),
        .bus       (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- SQI RAM model ----------------
    logic [15:0] mem [logic [15:0]];
    logic [3:0]  nib_q [$];
    int          mode_ones = 0;
    logic [15:0] m_addr = 16'h0;
    logic [15:0] m_rd = 16'h0;
    logic        cs_prev = 1'b1;

    function automatic logic [15:0] preload(input logic [15:0] a);
        case (a)
            16'h1234: return 16'hBEEF;
            16'h0000: return 16'h5A5A;
            default:  return 16'h0000;
        endcase
    endfunction

    always @(posedge bus.sqi_sck or bus.sqi_cs) begin
        if (cs_prev && !bus.sqi_cs) begin
            nib_q.delete();
            mode_ones = 0;
            bus.sqi_din = 4'h0;
        end else if (!cs_prev && bus.sqi_cs) begin
            if (nib_q.size() == 10 && {nib_q[0], nib_q[1]} == 8'h02)
                mem[{nib_q[2], nib_q[3], nib_q[4], nib_q[5]}] = {nib_q[6], nib_q[7], nib_q[8], nib_q[9]};
        end else if (bus.sqi_sck && !bus.sqi_cs) begin
            nib_q.push_back(bus.sqi_dout);
            if (bus.sqi_mode) mode_ones++;
            if (nib_q.size() == 6) m_addr = {nib_q[2], nib_q[3], nib_q[4], nib_q[5]};
            if (nib_q.size() == 8) m_rd = mem.exists(m_addr) ? mem[m_addr] : preload(m_addr);
            if (nib_q.size() >= 9 && {nib_q[0], nib_q[1]} == 8'h03)
                bus.sqi_din = m_rd[15 - 4 * (nib_q.size() - 9) -: 4];
        end
        cs_prev = bus.sqi_cs;
    end

    // ---------------- protocol monitor ----------------
    int viol = 0;
    int ndone = 0;
    int hi_run = 0;
    always @(negedge clk) begin
        if (bus.sqi_cs) hi_run++;
        else begin
            if (hi_run > 0 && hi_run < 2) viol++;
            hi_run = 0;
        end
        if (bus.sqi_cs && (bus.sqi_sck || bus.sqi_mode)) viol++;
        if (bus.f_done && bus.d_done) viol++;
        if (bus.f_done) ndone++;
        if (bus.d_done) ndone++;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic wait_done(output int lat, output bit gf, output bit gd);
        lat = 0; gf = 1'b0; gd = 1'b0;
        while (!(gf || gd) && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            gf = bus.f_done;
            gd = bus.d_done;
        end
        if (!(gf || gd)) begin
            total++;
            bad++;
            $display("FAIL timeout waiting for done got=none exp=done");
        end
    endtask

    task automatic check_frame(input bit wr, input logic [15:0] addr, input logic [15:0] wdata);
        logic [39:0] got;
        logic [39:0] exp;
        int n;
        got = '0;
        n = wr ? 10 : 6;
        for (int j = 0; j < n; j++) got = (got << 4) | 40'(nib_q[j]);
        exp = wr ? {8'h02, addr, wdata} : {16'h0, 8'h03, addr};
        check("frame", 64'(got), 64'(exp));
        check("nib_count", 64'(nib_q.size()), wr ? 64'd10 : 64'd12);
        check("mode_nibs", 64'(mode_ones), wr ? 64'd10 : 64'd6);
    endtask

    typedef struct {
        bit          is_d;
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          lat;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int lat;
        int lat2;
        bit gf, gd, gf2, gd2;
        logic [15:0] exp_f, exp_d;

        vecs[0] = '{1'b0, 1'b0, 16'h1234, 16'h0000, 16'hBEEF, 25};
        vecs[1] = '{1'b1, 1'b1, 16'h00A0, 16'hCAFE, 16'h0000, 21};
        vecs[2] = '{1'b1, 1'b0, 16'h00A0, 16'h0000, 16'hCAFE, 25};
        vecs[3] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h5A5A, 25};
        vecs[4] = '{1'b1, 1'b1, 16'hFFFF, 16'h0001, 16'h0000, 21};
        vecs[5] = '{1'b1, 1'b0, 16'h1234, 16'h0000, 16'hBEEF, 25};
        vecs[6] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0001, 25};

        bus.f_req = 1'b0; bus.f_addr = 16'h0;
        bus.d_req = 1'b0; bus.d_wr = 1'b0; bus.d_addr = 16'h0; bus.d_wdata = 16'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cs",      64'(bus.sqi_cs),   64'd1);
        check("rst_sck",     64'(bus.sqi_sck),  64'd0);
        check("rst_mode",    64'(bus.sqi_mode), 64'd0);
        check("rst_dout",    64'(bus.sqi_dout), 64'd0);
        check("rst_done",    64'({bus.f_done, bus.d_done}), 64'd0);
        check("rst_rdata",   64'({bus.f_rdata, bus.d_rdata}), 64'd0);
        $display("reset checked");
        rst = 1'b0;

        exp_f = 16'h0;
        exp_d = 16'h0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (vecs[i].is_d) begin
                bus.d_wr = vecs[i].wr; bus.d_addr = vecs[i].addr; bus.d_wdata = vecs[i].wdata;
                bus.d_req = 1'b1;
            end else begin
                bus.f_addr = vecs[i].addr;
                bus.f_req = 1'b1;
            end
            wait_done(lat, gf, gd);
            bus.f_req = 1'b0;
            bus.d_req = 1'b0;
            if (!vecs[i].wr) begin
                if (vecs[i].is_d) exp_d = vecs[i].rdata;
                else              exp_f = vecs[i].rdata;
            end
            check("latency", 64'(lat), 64'(vecs[i].lat));
            check("done_port", 64'({gf, gd}), vecs[i].is_d ? 64'd1 : 64'd2);
            check("f_rdata", 64'(bus.f_rdata), 64'(exp_f));
            check("d_rdata", 64'(bus.d_rdata), 64'(exp_d));
            check_frame(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            if (vecs[i].wr) check("mem_write", 64'(mem[vecs[i].addr]), 64'(vecs[i].wdata));
            $display("xfer %0d port=%s wr=%0d addr=%h lat=%0d f_rdata=%h d_rdata=%h",
                     i, vecs[i].is_d ? "d" : "f", vecs[i].wr, vecs[i].addr, lat, bus.f_rdata, bus.d_rdata);
        end

        // Both ports requesting across two consecutive arbitrations.
        @(negedge clk);
        bus.f_addr = 16'h1234; bus.f_req = 1'b1;
        bus.d_addr = 16'h00A0; bus.d_wr = 1'b0; bus.d_req = 1'b1;
        wait_done(lat, gf, gd);
        wait_done(lat2, gf2, gd2);
        bus.f_req = 1'b0;
        bus.d_req = 1'b0;
        check("arb_first", 64'({gf, gd}), 64'd1);
        check("arb_second", 64'({gf2, gd2}), RR ? 64'd2 : 64'd1);
        check("arb_lat2", 64'(lat2), 64'd26);
        check("arb_d_rdata", 64'(bus.d_rdata), 64'hCAFE);
        check("arb_f_rdata", 64'(bus.f_rdata), RR ? 64'hBEEF : 64'h0001);
        $display("arb first=%s second=%s lat2=%0d", gd ? "d" : "f", gd2 ? "d" : "f", lat2);

        // Reset while the address is being sent; the held request restarts afterwards.
        @(negedge clk);
        bus.f_addr = 16'h1234; bus.f_req = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("addr_cs_low", 64'(bus.sqi_cs), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_cs", 64'(bus.sqi_cs), 64'd1);
        check("midrst_mode", 64'(bus.sqi_mode), 64'd0);
        check("midrst_done", 64'({bus.f_done, bus.d_done}), 64'd0);
        check("midrst_rdata", 64'({bus.f_rdata, bus.d_rdata}), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_done(lat, gf, gd);
        bus.f_req = 1'b0;
        check("restart_lat", 64'(lat), 64'd25);
        check("restart_port", 64'({gf, gd}), 64'd2);
        check("restart_rdata", 64'(bus.f_rdata), 64'hBEEF);
        check_frame(1'b0, 16'h1234, 16'h0);
        $display("midframe reset restart lat=%0d f_rdata=%h", lat, bus.f_rdata);

        // Requester inputs change after grant; the frame must use the latched values.
        @(negedge clk);
        bus.d_wr = 1'b1; bus.d_addr = 16'h0200; bus.d_wdata = 16'h1357; bus.d_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.d_addr = 16'h0300; bus.d_wdata = 16'hFFFF; bus.d_wr = 1'b0;
        wait_done(lat, gf, gd);
        bus.d_req = 1'b0;
        check("latched_lat", 64'(lat), 64'd20);
        check("latched_port", 64'({gf, gd}), 64'd1);
        check("latched_mem", 64'(mem[16'h0200]), 64'h1357);
        check("latched_no_alias", 64'(mem.exists(16'h0300)), 64'd0);
        check_frame(1'b1, 16'h0200, 16'h1357);
        $display("latched write lat=%0d mem[0200]=%h", lat, mem[16'h0200]);

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("protocol_viol", 64'(viol), 64'd0);
        check("done_pulses", 64'(ndone), 64'd11);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
